multi_channel_controlled_counter: RTL

- Parametrised successor to the fixed two-channel controlled counter.
- NUM_CH independent up-counters, each with a runtime-programmable terminal value, are sequenced by a small FSM with a start/busy/done handshake.
- A registered W accumulator captures the zero-extended sum of all channel counts on load_w.
- Used as a stimulus/sequence generator feeding the W datapath.

---
 rtl/multi_channel_controlled_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/multi_channel_controlled_counter.sv
// NUM_CH programmable-limit up-counters sequenced by an IDLE/RUN/DONE FSM, plus a W sum register.
// Optional macro CC_PAUSE_EN adds a pause input that stalls RUN.
module multi_channel_controlled_counter #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 4,
    parameter int SUM_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_CH*CNT_W-1:0] limit_flat,
    input  logic                    load_w,
`ifdef CC_PAUSE_EN
    input  logic                    pause,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH-1:0]       ch_done,
    output logic [NUM_CH*CNT_W-1:0] count_flat,
    output logic [SUM_W-1:0]        w_output
);

    generate
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("NUM_CH must be in 1..8");
        end
        if (SUM_W < CNT_W + $clog2(NUM_CH)) begin : g_bad_sum_w
            $error("SUM_W too narrow for the channel sum");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   lim_q, lim_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   lim_in;
    logic [SUM_W-1:0]               w_q, w_d;
    logic                           run_en;
    logic                           all_hit;

    assign lim_in = limit_flat;

`ifdef CC_PAUSE_EN
    assign run_en = ~pause;
`else
    assign run_en = 1'b1;
`endif

    // Zero-extended sum of all channel counts; SUM_W is checked wide enough above.
    function automatic logic [SUM_W-1:0] chan_sum(input logic [NUM_CH-1:0][CNT_W-1:0] c);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc = acc + SUM_W'(c[i]);
        end
        return acc;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        w_d     = load_w ? chan_sum(cnt_q) : w_q;
        all_hit = 1'b1;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lim_d   = lim_in;
                    cnt_d   = '0;
                    state_d = (lim_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (run_en) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (cnt_q[i] < lim_q[i]) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                        if (cnt_d[i] != lim_q[i]) begin
                            all_hit = 1'b0;
                        end
                    end
                    if (all_hit) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        ch_done = '0;
        if (state_q != IDLE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_done[i] = (cnt_q[i] == lim_q[i]);
            end
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign count_flat = cnt_q;
    assign w_output   = w_q;

endmodule
